// File: rtl/fsm_rr_detect_sched.sv
// Round-robin scheduler sharing one serial run-of-ones detector.
// One burst in flight; result reported on a one-cycle strobe.
module fsm_rr_detect_sched #(
  parameter int SRC_W     = 2,
  parameter int BURST_LEN = 8,
  parameter int RUN_LEN   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2**SRC_W-1:0]   req,
  input  logic [2**SRC_W-1:0]   bit_in,
  output logic [2**SRC_W-1:0]   gnt,
  output logic                  busy,
  output logic                  det_valid,
  output logic [SRC_W-1:0]      det_src,
  output logic                  det_hit,
  output logic                  det_abort
);

  localparam int N_REQ = 2**SRC_W;
  localparam int CNT_W = 8;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] RUN_MAX  = CNT_W'(RUN_LEN);
  localparam logic [SRC_W-1:0] PTR_INIT = SRC_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  state_t             state_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [SRC_W-1:0]   last_q;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [CNT_W-1:0]   run_cnt_q;
  logic               hit_q;
  logic               busy_q;
  logic               det_valid_q;
  logic [SRC_W-1:0]   det_src_q;
  logic               det_hit_q;
  logic               det_abort_q;

  logic               win_found;
  logic [SRC_W-1:0]   win_idx;
  logic [SRC_W-1:0]   scan_idx;
  logic [N_REQ-1:0]   win_onehot;

  logic               samp;
  logic               req_held;
  logic               last_smp;
  logic [CNT_W-1:0]   run_inc;
  logic [CNT_W-1:0]   run_d;
  logic               hit_d;

  // Scan starts one past the last winner; width wrap gives mod N_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan_idx = last_q + SRC_W'(k);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
  end

  always_comb begin
    samp     = bit_in[last_q];
    req_held = req[last_q];
    last_smp = (bit_cnt_q == LAST_BIT);
    run_inc  = (run_cnt_q == RUN_MAX) ? run_cnt_q
                                      : run_cnt_q + CNT_W'(1);
    run_d    = samp ? run_inc : '0;
    hit_d    = hit_q | (run_d == RUN_MAX);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      last_q      <= PTR_INIT;
      bit_cnt_q   <= '0;
      run_cnt_q   <= '0;
      hit_q       <= 1'b0;
      busy_q      <= 1'b0;
      det_valid_q <= 1'b0;
      det_src_q   <= '0;
      det_hit_q   <= 1'b0;
      det_abort_q <= 1'b0;
    end else begin
      det_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (win_found) begin
            state_q   <= ST_RUN;
            gnt_q     <= win_onehot;
            last_q    <= win_idx;
            busy_q    <= 1'b1;
            bit_cnt_q <= '0;
            run_cnt_q <= '0;
            hit_q     <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!req_held) begin
            // Dropped request: this cycle's bit is discarded.
            state_q     <= ST_REPORT;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            det_valid_q <= 1'b1;
            det_src_q   <= last_q;
            det_hit_q   <= hit_q;
            det_abort_q <= 1'b1;
          end else begin
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            run_cnt_q <= run_d;
            hit_q     <= hit_d;
            if (last_smp) begin
              state_q     <= ST_REPORT;
              gnt_q       <= '0;
              busy_q      <= 1'b0;
              det_valid_q <= 1'b1;
              det_src_q   <= last_q;
              det_hit_q   <= hit_d;
              det_abort_q <= 1'b0;
            end
          end
        end
        ST_REPORT: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign det_valid = det_valid_q;
  assign det_src   = det_src_q;
  assign det_hit   = det_hit_q;
  assign det_abort = det_abort_q;

endmodule

// File: tb/tb_fsm_rr_detect_sched.sv
// Bench for fsm_rr_detect_sched: directed scenarios plus random
// traffic against a burst-level reference model.
module tb_fsm_rr_detect_sched;

  localparam int SRC_W = 2;
  localparam int N     = 4;
  localparam int BL    = 8;
  localparam int RL    = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] bit_in;
  logic [3:0] gnt;
  logic       busy;
  logic       det_valid;
  logic [1:0] det_src;
  logic       det_hit;
  logic       det_abort;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fsm_rr_detect_sched #(
    .SRC_W(SRC_W),
    .BURST_LEN(BL),
    .RUN_LEN(RL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .bit_in(bit_in),
    .gnt(gnt),
    .busy(busy),
    .det_valid(det_valid),
    .det_src(det_src),
    .det_hit(det_hit),
    .det_abort(det_abort)
  );

  logic [9:0] dut_vec;
  assign dut_vec = {gnt, busy, det_valid, det_src, det_hit, det_abort};

  // Reference model: burst-level view (idle / collecting / reporting).
  int         m_mode;
  int         m_last;
  bit         m_bits[$];
  logic [3:0] m_gnt;
  logic       m_busy, m_dv, m_hit, m_abort;
  logic [1:0] m_src;

  function automatic bit has_run();
    for (int s = 0; s + RL <= m_bits.size(); s++) begin
      bit all1 = 1'b1;
      for (int j = 0; j < RL; j++)
        if (!m_bits[s+j]) all1 = 1'b0;
      if (all1) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [9:0] exp_vec();
    return {m_gnt, m_busy, m_dv, m_src, m_hit, m_abort};
  endfunction

  task automatic finish_burst(input bit ab);
    m_gnt   = 4'b0;
    m_busy  = 1'b0;
    m_dv    = 1'b1;
    m_src   = 2'(m_last);
    m_hit   = has_run();
    m_abort = ab;
    m_mode  = 2;
  endtask

  task automatic model_step(input logic rn, input logic [3:0] r,
                            input logic [3:0] b);
    if (!rn) begin
      m_mode = 0; m_last = N - 1; m_bits.delete();
      m_gnt = 0; m_busy = 0; m_dv = 0;
      m_src = 0; m_hit = 0; m_abort = 0;
    end else if (m_mode == 0) begin
      m_dv = 1'b0;
      if (r != 4'b0) begin
        int w = -1;
        for (int k = 1; k <= N; k++) begin
          int idx = (m_last + k) % N;
          if (w < 0 && r[idx]) w = idx;
        end
        m_last = w;
        m_gnt  = 4'b0;
        m_gnt[w] = 1'b1;
        m_busy = 1'b1;
        m_bits.delete();
        m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (!r[m_last]) finish_burst(1'b1);
      else begin
        m_bits.push_back(b[m_last]);
        if (m_bits.size() == BL) finish_burst(1'b0);
      end
    end else begin
      m_dv   = 1'b0;
      m_mode = 0;
    end
  endtask

  task automatic tick(input logic rn, input logic [3:0] r,
                      input logic [3:0] b);
    @(negedge clk);
    reset  = rn;
    req    = r;
    bit_in = b;
    @(posedge clk);
    model_step(rn, r, b);
    #1;
  endtask

  task automatic test_reset();
    tick(1'b0, 4'hF, 4'hF);
    tick(1'b0, 4'hF, 4'hF);
    n_cmp++;
    if (dut_vec !== 10'b0) begin
      n_err++;
      $display("FAIL reset: got %b want %b", dut_vec, 10'b0);
    end
    tick(1'b1, 4'b0, 4'b0);
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_err++;
      $display("FAIL reset_idle: got %b want %b", dut_vec, exp_vec());
    end
  endtask

  task automatic test_round_robin();
    int         srcs[$];
    int         cyc[$];
    logic [3:0] gseq[$];
    int         glen[$];
    int         hi = 0;
    logic [3:0] prev = 4'b0;
    logic [3:0] want_g[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int         want_s[5] = '{0, 1, 2, 3, 0};
    tick(1'b0, 4'b0, 4'b0);
    for (int c = 1; c <= 50; c++) begin
      tick(1'b1, 4'hF, 4'($urandom));
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL rr_cycle%0d: got %b want %b", c, dut_vec, exp_vec());
      end
      if (det_valid) begin
        srcs.push_back(int'(det_src));
        cyc.push_back(c);
      end
      if (gnt != 4'b0 && prev == 4'b0) gseq.push_back(gnt);
      if (gnt != 4'b0) hi++;
      else if (prev != 4'b0) begin
        glen.push_back(hi);
        hi = 0;
      end
      prev = gnt;
    end
    n_cmp++;
    if (srcs.size() != 5 || gseq.size() < 5 || glen.size() != 5) begin
      n_err++;
      $display("FAIL rr_counts: dv=%0d gnt=%0d len=%0d want 5 5 5",
               srcs.size(), gseq.size(), glen.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (srcs[i] != want_s[i] || gseq[i] !== want_g[i] || glen[i] != BL
            || (i > 0 && cyc[i] - cyc[i-1] != BL + 2)) begin
          n_err++;
          $display("FAIL rr_burst%0d: src=%0d gnt=%b len=%0d want %0d %b %0d",
                   i, srcs[i], gseq[i], glen[i], want_s[i], want_g[i], BL);
        end
      end
    end
  endtask

  task automatic run_pattern(input string nm, input logic [3:0] r,
                             input int lane, input logic [7:0] pat);
    tick(1'b0, 4'b0, 4'b0);
    tick(1'b1, r, 4'b0);
    for (int i = 0; i < BL; i++) begin
      logic [3:0] b = 4'b0;
      b[lane] = pat[i];
      tick(1'b1, r, b);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL %s_cycle%0d: got %b want %b", nm, i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_no_hit();
    run_pattern("nohit", 4'b0001, 0, 8'b0101_0101);
    n_cmp++;
    if ({det_valid, det_src, det_hit, det_abort} !== 5'b1_00_0_0) begin
      n_err++;
      $display("FAIL nohit_result: got %b want %b",
               {det_valid, det_src, det_hit, det_abort}, 5'b1_00_0_0);
    end
  endtask

  task automatic test_hit_last();
    run_pattern("hitlast", 4'b0100, 2, 8'b1100_0000);
    n_cmp++;
    if ({det_valid, det_src, det_hit, det_abort} !== 5'b1_10_1_0) begin
      n_err++;
      $display("FAIL hitlast_result: got %b want %b",
               {det_valid, det_src, det_hit, det_abort}, 5'b1_10_1_0);
    end
  endtask

  task automatic test_abort();
    logic [2:0] bits = 3'b011;
    tick(1'b0, 4'b0, 4'b0);
    tick(1'b1, 4'b0010, 4'b0);
    n_cmp++;
    if (gnt !== 4'b0010) begin
      n_err++;
      $display("FAIL abort_grant: got %b want %b", gnt, 4'b0010);
    end
    for (int i = 0; i < 3; i++) tick(1'b1, 4'b0010, {2'b0, bits[i], 1'b0});
    tick(1'b1, 4'b1101, 4'b0010);
    n_cmp++;
    if (dut_vec !== {4'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1}
        || dut_vec !== exp_vec()) begin
      n_err++;
      $display("FAIL abort_result: got %b want %b", dut_vec, exp_vec());
    end
    tick(1'b1, 4'hF, 4'b0);
    tick(1'b1, 4'hF, 4'b0);
    n_cmp++;
    if (gnt !== 4'b0100 || dut_vec !== exp_vec()) begin
      n_err++;
      $display("FAIL abort_rearb: got %b want gnt %b", gnt, 4'b0100);
    end
  endtask

  task automatic test_reset_midburst();
    bit seen_dv = 1'b0;
    tick(1'b0, 4'b0, 4'b0);
    tick(1'b1, 4'hF, 4'b0);
    for (int i = 0; i < 3; i++) tick(1'b1, 4'hF, 4'($urandom));
    tick(1'b0, 4'hF, 4'hF);
    n_cmp++;
    if (dut_vec !== 10'b0) begin
      n_err++;
      $display("FAIL midreset: got %b want %b", dut_vec, 10'b0);
    end
    tick(1'b1, 4'b0110, 4'b0);
    n_cmp++;
    if (gnt !== 4'b0010) begin
      n_err++;
      $display("FAIL midreset_grant: got %b want %b", gnt, 4'b0010);
    end
    for (int i = 0; i < BL + 2; i++) begin
      tick(1'b1, 4'b0110, 4'($urandom));
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL midreset_cycle%0d: got %b want %b", i, dut_vec, exp_vec());
      end
    end
    if (det_valid) seen_dv = 1'b1;
  endtask

  task automatic test_idle();
    tick(1'b0, 4'b0, 4'b0);
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 4'b0, 4'($urandom));
      n_cmp++;
      if (gnt !== 4'b0 || busy !== 1'b0 || det_valid !== 1'b0) begin
        n_err++;
        $display("FAIL idle_cycle%0d: got gnt=%b busy=%b dv=%b want 0 0 0",
                 i, gnt, busy, det_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] r = 4'hF;
    tick(1'b0, 4'b0, 4'b0);
    for (int i = 0; i < 1500; i++) begin
      logic rn = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 7) == 0) r = 4'($urandom);
      tick(rn, r, 4'($urandom));
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL random_cycle%0d: got %b want %b", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    reset  = 1'b0;
    req    = 4'b0;
    bit_in = 4'b0;
    test_reset();
    test_round_robin();
    test_no_hit();
    test_hit_last();
    test_abort();
    test_reset_midburst();
    test_idle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
